// File: rtl/wide_add_pkg.sv
// -----------------------------------------------------------------------------
// wide_add_pkg
// Shared definitions for the wide add/subtract sequencer.
//   SLICE_W       : width of one slice, which is also the width of the shared adder
//   state_e       : sequencer states (idle, slice processing, result hold)
//   slice_count() : number of adder slices needed for a given operand width
// -----------------------------------------------------------------------------
package wide_add_pkg;

    localparam int unsigned SLICE_W = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Operand widths are multiples of SLICE_W, so the division is exact.
    function automatic int unsigned slice_count(input int unsigned width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/cla_16.sv
// -----------------------------------------------------------------------------
// cla_16
// 16-bit two-level carry-lookahead adder. It is built from four 4-bit groups.
// Each group produces its own generate and propagate signals. A second lookahead
// level uses these to form the carry into each group. Purely combinational.
//   a, b : addends
//   cin  : carry in
//   sum  : a + b + cin, modulo 2^16
//   cout : carry out of bit 15
// -----------------------------------------------------------------------------
module cla_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] g;   // bit generate
    logic [15:0] p;   // bit propagate
    logic [15:0] c;   // carry into each bit
    logic [3:0]  gg;  // group generate
    logic [3:0]  gp;  // group propagate
    logic [4:0]  gc;  // carry into each group; gc[4] is the final carry out

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;

        for (int k = 0; k < 4; k++) begin
            gp[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end

        // Second level: group carries depend only on cin and group g/p.
        gc[0] = cin;
        gc[1] = gg[0] | (gp[0] & cin);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & cin);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

        // First level: bit carries inside each group, seeded by the group carry.
        for (int k = 0; k < 4; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
    end

    assign sum  = p ^ c;
    assign cout = gc[4];

endmodule

// File: rtl/wide_add_seq.sv
// -----------------------------------------------------------------------------
// wide_add_seq
// Multi-cycle WIDTH-bit adder/subtractor. It shares one cla_16 across all
// 16-bit slices and processes one slice per clock, starting with the least
// significant slice. A register carries the slice carry from one cycle to the
// next.
// The operation is WIDTH bits wide. WIDTH must be a multiple of 16 and at least 32.
//   clk, rst_n          : clock and asynchronous active-low reset
//   in_valid, in_ready  : request handshake; a, b and sub are sampled on it
//   a, b                : operands
//   sub                 : 0 selects a+b, 1 selects a-b
//   out_valid, out_ready: result handshake; the outputs hold while out_valid is high
//   sum                 : result modulo 2^WIDTH
//   cout                : carry out of the MSB (for subtract, 1 means no borrow)
//   ovf                 : two's-complement signed overflow
// -----------------------------------------------------------------------------
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NS       = slice_count(WIDTH);
    localparam int unsigned IDX_W    = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NS - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;      // B already inverted for subtract
    logic               carry_q;  // carry into the current slice
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovf_q;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               last_slice;

    // The adder sees only the latched operands, so the input ports are free to change
    // during RUN.
    assign slice_a    = a_q[idx_q*SLICE_W +: SLICE_W];
    assign slice_b    = b_q[idx_q*SLICE_W +: SLICE_W];
    assign last_slice = (idx_q == LAST_IDX);

    cla_16 u_cla (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        // Subtract is A + ~B + 1. The +1 enters as the carry into
                        // the first slice, so the sub flag needs no separate register.
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    sum_q[idx_q*SLICE_W +: SLICE_W] <= slice_sum;
                    carry_q <= slice_cout;
                    if (last_slice) begin
                        cout_q  <= slice_cout;
                        // Overflow occurs when both addends have the same sign but the
                        // result sign differs. The MSB of the top slice is the result sign.
                        ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                   (slice_sum[SLICE_W-1] != a_q[WIDTH-1]);
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// -----------------------------------------------------------------------------
// tb_wide_add_seq
// Self-checking bench for wide_add_seq at WIDTH = 64. It runs directed cases
// first, then checks back-pressure hold, then asserts reset in the middle of an
// operation, and finally runs randomized operations against an arithmetic
// reference model.
// -----------------------------------------------------------------------------
module tb_wide_add_seq;

    localparam int unsigned W = 64;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_pass   = 0;

    wide_add_seq #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model. It uses whole-word unsigned and signed arithmetic.
    function automatic void model(input logic [63:0] x, input logic [63:0] y, input logic s,
                                  output logic [63:0] r, output logic c, output logic v);
        logic [64:0]        wide;
        logic signed [65:0] exact;
        logic signed [65:0] wrapped;
        if (s) begin
            r     = x - y;
            c     = (x >= y);
            exact = $signed(x) - $signed(y);
        end else begin
            wide  = {1'b0, x} + {1'b0, y};
            r     = wide[63:0];
            c     = wide[64];
            exact = $signed(x) + $signed(y);
        end
        wrapped = $signed(r);
        v = (exact != wrapped);
    endfunction

    // Accept one request, scramble the inputs, then wait for the result and check it.
    task automatic start_op(input string tag, input logic [63:0] xa, input logic [63:0] xb,
                            input logic xs, input logic [63:0] er, input logic ec,
                            input logic ev);
        int lat;
        @(negedge clk);
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        a        = xa;
        b        = xb;
        sub      = xs;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = {$urandom(), $urandom()};
        b        = {$urandom(), $urandom()};
        sub      = 1'($urandom());
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd4);
        check({tag, " sum"}, sum, er);
        check({tag, " cout"}, 64'(cout), 64'(ec));
        check({tag, " ovf"}, 64'(ovf), 64'(ev));
    endtask

    // Hold the result for some cycles with out_ready low, then hand it off.
    task automatic finish_op(input string tag, input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold valid"}, 64'(out_valid), 64'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " idle ready"}, 64'(in_ready), 64'd1);
        check({tag, " idle valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        logic [63:0] er;
        logic        rs;
        logic        ec;
        logic        ev;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;

        #12;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset sum", sum, 64'd0);
        check("reset cout", 64'(cout), 64'd0);
        check("reset ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic cases
        start_op("add carry16", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0,
                 64'h0000_0000_0001_0000, 1'b0, 1'b0);
        finish_op("add carry16", 0);
        start_op("add wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0);
        finish_op("add wrap", 1);
        start_op("add ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        finish_op("add ovf", 0);
        start_op("sub borrow", 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        finish_op("sub borrow", 0);
        start_op("sub ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b1,
                 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

        // Back-pressure: the result holds and no request is taken while out_ready is low
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            a        = {$urandom(), $urandom()};
            b        = {$urandom(), $urandom()};
            sub      = 1'($urandom());
            check("bp sum", sum, 64'h7FFF_FFFF_FFFF_FFFF);
            check("bp cout", 64'(cout), 64'd1);
            check("bp ovf", 64'(ovf), 64'd1);
            check("bp in_ready", 64'(in_ready), 64'd0);
            check("bp out_valid", 64'(out_valid), 64'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        finish_op("bp", 0);
        start_op("bp next", 64'd1, 64'd2, 1'b0, 64'd3, 1'b0, 1'b0);
        finish_op("bp next", 0);

        // Reset while slice 2 is being processed
        @(negedge clk);
        a        = 64'h1111_1111_1111_1111;
        b        = 64'h2222_2222_2222_2222;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid run in_ready", 64'(in_ready), 64'd0);
        check("mid run out_valid", 64'(out_valid), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst run in_ready", 64'(in_ready), 64'd1);
        check("rst run out_valid", 64'(out_valid), 64'd0);
        check("rst run sum", sum, 64'd0);
        check("rst run cout", 64'(cout), 64'd0);
        check("rst run ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_op("after rst", 64'd10, 64'd20, 1'b0, 64'd30, 1'b0, 1'b0);
        finish_op("after rst", 0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            rs = 1'($urandom());
            if ((i % 8) == 3) rb = ~ra;
            if ((i % 8) == 5) ra = {1'b0, ra[62:0]} | 64'h7FFF_0000_0000_0000;
            model(ra, rb, rs, er, ec, ev);
            start_op("rand", ra, rb, rs, er, ec, ev);
            finish_op("rand", int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
